// File: rtl/bp_pkg.sv
// Types and constants shared by the branch predictor, the BHT and the decoder.
// Tags are stored zero-extended to the widest possible tag, so any SETS fits one entry type.
package bp_pkg;

  localparam int DEF_SETS  = 32;
  localparam int DEF_CNT_W = 16;
  localparam int TAG_MAX_W = 30;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BR_BEQ   = 3'd1,
    BR_BNE   = 3'd2,
    BR_BLT   = 3'd3,
    BR_BGE   = 3'd4,
    BR_BLTU  = 3'd5,
    BR_BGEU  = 3'd6,
    BR_JUMP  = 3'd7
  } branch_type_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int index_w);
    logic [31:0] shifted;
    shifted = pc >> (index_w + 2);
    return shifted[TAG_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: valid bits with asynchronous clear, tag/target storage with no reset.
// Two asynchronous read ports (fetch lookup and EX training) and one synchronous write port.
module btb_way
  import bp_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  localparam int INDEX_W = $clog2(SETS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   rd_index_a,
  output btb_entry_t           rd_entry_a,
  input  logic [INDEX_W-1:0]   rd_index_b,
  output btb_entry_t           rd_entry_b,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_index,
  input  logic [TAG_MAX_W-1:0] wr_tag,
  input  logic [31:0]          wr_target
);

  logic [SETS-1:0]      valid_bits;
  logic [TAG_MAX_W-1:0] tag_mem    [SETS];
  logic [31:0]          target_mem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Tag/target contents are don't-care until the valid bit is set, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]    <= wr_tag;
      target_mem[wr_index] <= wr_target;
    end
  end

  always_comb begin
    rd_entry_a.valid  = valid_bits[rd_index_a];
    rd_entry_a.tag    = tag_mem[rd_index_a];
    rd_entry_a.target = target_mem[rd_index_a];
    rd_entry_b.valid  = valid_bits[rd_index_b];
    rd_entry_b.tag    = tag_mem[rd_index_b];
    rd_entry_b.target = target_mem[rd_index_b];
  end

endmodule

// File: rtl/btb_predictor.sv
// Fetch-stage next-PC predictor: 2-way BTB lookup in IF, branch resolve and BTB training in EX,
// plus saturating accuracy counters.
module btb_predictor
  import bp_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int CNT_W = DEF_CNT_W,
  localparam int INDEX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  input  logic             bht_taken_f,
  output logic [31:0]      npc_pred_f,
  output logic             pred_taken_f,
  output logic             btb_hit_f,
  input  logic [31:0]      PCE,
  input  logic [2:0]       branch_type_e,
  input  logic             real_taken_e,
  input  logic [31:0]      real_target_e,
  input  logic             pred_taken_e,
  input  logic [31:0]      pred_target_e,
  output logic             mispredict_e,
  output logic [31:0]      redirect_pc_e,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic [INDEX_W-1:0]   index_f, index_e;
  logic [TAG_MAX_W-1:0] tag_f, tag_e;
  btb_entry_t           entry_f [2];
  btb_entry_t           entry_e [2];
  logic [1:0]           way_hit_f, way_hit_e, way_wr_en;

  logic [SETS-1:0] lru_bits;
  logic            is_branch;
  logic            victim;
  logic            lru_we;
  logic            lru_value;

  assign index_f = PCF[INDEX_W+1:2];
  assign index_e = PCE[INDEX_W+1:2];
  assign tag_f   = pc_tag(PCF, INDEX_W);
  assign tag_e   = pc_tag(PCE, INDEX_W);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      btb_way #(.SETS(SETS)) u_way (
        .clk        (clk),
        .rst        (rst),
        .rd_index_a (index_f),
        .rd_entry_a (entry_f[gi]),
        .rd_index_b (index_e),
        .rd_entry_b (entry_e[gi]),
        .wr_en      (way_wr_en[gi]),
        .wr_index   (index_e),
        .wr_tag     (tag_e),
        .wr_target  (real_target_e)
      );
      assign way_hit_f[gi] = entry_f[gi].valid && (entry_f[gi].tag == tag_f);
      assign way_hit_e[gi] = entry_e[gi].valid && (entry_e[gi].tag == tag_e);
    end
  endgenerate

  // Lookup: way0 takes priority if both ways ever match.
  assign btb_hit_f    = |way_hit_f;
  assign pred_taken_f = btb_hit_f & bht_taken_f;
  assign npc_pred_f   = pred_taken_f ? (way_hit_f[0] ? entry_f[0].target : entry_f[1].target)
                                     : PCF + 32'd4;

  // Resolve
  assign is_branch     = (branch_type_e != NOBRANCH);
  assign mispredict_e  = is_branch &&
                         ((pred_taken_e != real_taken_e) ||
                          (pred_taken_e && real_taken_e && (pred_target_e != real_target_e)));
  assign redirect_pc_e = real_taken_e ? real_target_e : PCE + 32'd4;

  // Train: pick the way to write and the new LRU value for the EX set.
  always_comb begin
    way_wr_en = 2'b00;
    lru_we    = 1'b0;
    lru_value = 1'b0;
    victim    = 1'b0;
    if (!entry_e[0].valid) begin
      victim = 1'b0;
    end else if (!entry_e[1].valid) begin
      victim = 1'b1;
    end else begin
      victim = lru_bits[index_e];
    end
    if (is_branch) begin
      if (way_hit_e[0]) begin
        way_wr_en[0] = real_taken_e;
        lru_we       = 1'b1;
        lru_value    = 1'b1;
      end else if (way_hit_e[1]) begin
        way_wr_en[1] = real_taken_e;
        lru_we       = 1'b1;
        lru_value    = 1'b0;
      end else if (real_taken_e) begin
        way_wr_en[victim] = 1'b1;
        lru_we            = 1'b1;
        lru_value         = ~victim;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_bits <= '0;
    end else if (lru_we) begin
      lru_bits[index_e] <= lru_value;
    end
  end

  // Statistics saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count        <= '0;
      mispredict_count <= '0;
    end else if (is_branch) begin
      if (mispredict_e) begin
        if (mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
      end else if (pred_taken_e) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized and directed bench for btb_predictor against a set/way reference model.
module tb_btb_predictor;
  import bp_pkg::*;

  localparam int SETS  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      PCF;
  logic             bht_taken_f;
  logic [31:0]      npc_pred_f;
  logic             pred_taken_f;
  logic             btb_hit_f;
  logic [31:0]      PCE;
  logic [2:0]       branch_type_e;
  logic             real_taken_e;
  logic [31:0]      real_target_e;
  logic             pred_taken_e;
  logic [31:0]      pred_target_e;
  logic             mispredict_e;
  logic [31:0]      redirect_pc_e;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  btb_predictor #(.SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .bht_taken_f(bht_taken_f), .npc_pred_f(npc_pred_f),
    .pred_taken_f(pred_taken_f), .btb_hit_f(btb_hit_f), .PCE(PCE), .branch_type_e(branch_type_e),
    .real_taken_e(real_taken_e), .real_target_e(real_target_e), .pred_taken_e(pred_taken_e),
    .pred_target_e(pred_target_e), .mispredict_e(mispredict_e), .redirect_pc_e(redirect_pc_e),
    .hit_count(hit_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Reference model: per-set list of (valid, pc tag, target) for two ways and an eviction pointer.
  bit          m_valid [2][SETS];
  int unsigned m_tag   [2][SETS];
  logic [31:0] m_tgt   [2][SETS];
  int          m_lru   [SETS];
  int          m_hits, m_mis;

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * SETS);
  endfunction

  function automatic int find_way(input logic [31:0] pc);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][set_of(pc)] && m_tag[w][set_of(pc)] == tag_of(pc)) return w;
    return -1;
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic bht);
    int w;
    w = find_way(pc);
    if (w >= 0 && bht) return m_tgt[w][set_of(pc)];
    return pc + 32'd4;
  endfunction

  function automatic logic model_mis();
    if (branch_type_e == NOBRANCH) return 1'b0;
    if (pred_taken_e != real_taken_e) return 1'b1;
    return pred_taken_e && real_taken_e && (pred_target_e != real_target_e);
  endfunction

  function automatic logic [31:0] model_redirect();
    return real_taken_e ? real_target_e : PCE + 32'd4;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[0][s] = 0; m_valid[1][s] = 0; m_lru[s] = 0;
    end
    m_hits = 0; m_mis = 0;
  endtask

  task automatic set_in(input logic [31:0] pcf, input logic bht, input logic [31:0] pce,
                        input logic [2:0] bt, input logic rt, input logic [31:0] rtgt,
                        input logic pt, input logic [31:0] ptgt);
    PCF = pcf; bht_taken_f = bht; PCE = pce; branch_type_e = bt; real_taken_e = rt;
    real_target_e = rtgt; pred_taken_e = pt; pred_target_e = ptgt;
    #1;
  endtask

  // Advance one clock, then apply the training/counter rules to the model.
  task automatic tick();
    int s, w, v;
    bit br, mp;
    br = (branch_type_e != NOBRANCH);
    mp = model_mis();
    @(posedge clk);
    if (!rst && br) begin
      s = set_of(PCE);
      w = find_way(PCE);
      if (w >= 0) begin
        if (real_taken_e) m_tgt[w][s] = real_target_e;
        m_lru[s] = 1 - w;
      end else if (real_taken_e) begin
        v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : m_lru[s]);
        m_valid[v][s] = 1; m_tag[v][s] = tag_of(PCE); m_tgt[v][s] = real_target_e;
        m_lru[s] = 1 - v;
      end
      if (mp) begin
        if (m_mis < CMAX) m_mis++;
      end else if (pred_taken_e) begin
        if (m_hits < CMAX) m_hits++;
      end
    end
    #1;
    $display("txn t=%0t pcf=%h pce=%h bt=%0d rt=%0d pt=%0d mis=%0d hits=%0d misc=%0d",
             $time, PCF, PCE, branch_type_e, real_taken_e, pred_taken_e, mp,
             hit_count, mispredict_count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    set_in(32'h40, 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); tick();
    total++;
    if (btb_hit_f !== 1'b0 || npc_pred_f !== 32'h44) begin
      bad++; $display("FAIL reset_lookup hit=%b npc=%h want hit=0 npc=00000044", btb_hit_f, npc_pred_f);
    end
    rst = 1'b0;
    #1;
    total++;
    if (hit_count !== '0 || mispredict_count !== '0 || pred_taken_f !== 1'b0) begin
      bad++; $display("FAIL reset_counters hits=%0d mis=%0d pt=%b want 0 0 0", hit_count, mispredict_count, pred_taken_f);
    end
  endtask

  task automatic test_first_mispredict();
    set_in(32'h40, 1'b1, 32'h40, BR_BEQ, 1'b1, 32'h100, 1'b0, 32'h44);
    total++;
    if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h100) begin
      bad++; $display("FAIL first_mispredict mis=%b redir=%h want 1 00000100", mispredict_e, redirect_pc_e);
    end
    total++;
    if (npc_pred_f !== 32'h44) begin
      bad++; $display("FAIL read_before_write npc=%h want 00000044", npc_pred_f);
    end
    tick();
    set_in(32'h40, 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (mispredict_count !== 4'd1 || btb_hit_f !== 1'b1 || npc_pred_f !== 32'h100) begin
      bad++; $display("FAIL first_train misc=%0d hit=%b npc=%h want 1 1 00000100", mispredict_count, btb_hit_f, npc_pred_f);
    end
  endtask

  task automatic test_eviction();
    logic [31:0] pcs [3];
    pcs[0] = 32'h000; pcs[1] = 32'h080; pcs[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h0, 1'b0, pcs[i], BR_BNE, 1'b1, 32'h1000 + 32'(i) * 32'h100, 1'b0, pcs[i] + 32'd4);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(pcs[i], 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
      total++;
      if (btb_hit_f !== (i != 0) || npc_pred_f !== model_npc(pcs[i], 1'b1)) begin
        bad++; $display("FAIL evict_lookup pc=%h hit=%b npc=%h want hit=%b npc=%h",
                        pcs[i], btb_hit_f, npc_pred_f, (i != 0), model_npc(pcs[i], 1'b1));
      end
    end
  endtask

  task automatic test_target_mismatch();
    set_in(32'h0, 1'b0, 32'h40, BR_BLT, 1'b1, 32'h200, 1'b1, 32'h100);
    total++;
    if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h200) begin
      bad++; $display("FAIL target_mismatch mis=%b redir=%h want 1 00000200", mispredict_e, redirect_pc_e);
    end
    tick();
    set_in(32'h40, 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (npc_pred_f !== 32'h200) begin
      bad++; $display("FAIL retrain npc=%h want 00000200", npc_pred_f);
    end
  endtask

  task automatic test_not_taken();
    logic [CNT_W-1:0] h0, m0;
    h0 = hit_count; m0 = mispredict_count;
    set_in(32'h0, 1'b0, 32'h40, BR_BGE, 1'b0, 32'h200, 1'b0, 32'h44);
    total++;
    if (mispredict_e !== 1'b0) begin
      bad++; $display("FAIL nt_correct mis=%b want 0", mispredict_e);
    end
    tick();
    total++;
    if (hit_count !== h0 || mispredict_count !== m0) begin
      bad++; $display("FAIL nt_counters hits=%0d mis=%0d want %0d %0d", hit_count, mispredict_count, h0, m0);
    end
    set_in(32'h40, 1'b1, 32'h40, BR_BGE, 1'b0, 32'h200, 1'b1, 32'h200);
    total++;
    if (mispredict_e !== 1'b1 || redirect_pc_e !== 32'h44) begin
      bad++; $display("FAIL nt_mispredict mis=%b redir=%h want 1 00000044", mispredict_e, redirect_pc_e);
    end
    tick();
    set_in(32'h40, 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (npc_pred_f !== 32'h200) begin
      bad++; $display("FAIL nt_keeps_entry npc=%h want 00000200", npc_pred_f);
    end
  endtask

  task automatic test_wrap();
    set_in(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, BR_BEQ, 1'b0, 32'h0, 1'b1, 32'h300);
    total++;
    if (npc_pred_f !== 32'h0 || redirect_pc_e !== 32'h0 || mispredict_e !== 1'b1) begin
      bad++; $display("FAIL pc_wrap npc=%h redir=%h mis=%b want 0 0 1", npc_pred_f, redirect_pc_e, mispredict_e);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 2; i++) begin
      set_in(32'h0, 1'b0, 32'h800, BR_BNE, 1'b0, 32'h0, 1'b1, 32'h900);
      tick();
    end
    total++;
    if (mispredict_count !== 4'hF || m_mis != CMAX) begin
      bad++; $display("FAIL mis_saturate mis=%0d model=%0d want 15", mispredict_count, m_mis);
    end
  endtask

  task automatic test_random();
    logic [31:0] pce, pcf, exp_npc;
    logic bht, pt, rt;
    int w;
    for (int i = 0; i < 400; i++) begin
      pcf = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 2);
      pce = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 3)) << 2);
      bht = 1'($urandom_range(0, 1));
      rt  = 1'($urandom_range(0, 1));
      w   = find_way(pce);
      pt  = (w >= 0) && ($urandom_range(0, 3) != 0);
      set_in(pcf, bht, pce, 3'($urandom_range(0, 7)), rt,
             32'h4000 + (32'($urandom_range(0, 3)) << 4), pt,
             pt ? model_npc(pce, 1'b1) : pce + 32'd4);
      exp_npc = model_npc(pcf, bht);
      total++;
      if (btb_hit_f !== (find_way(pcf) >= 0) || pred_taken_f !== ((find_way(pcf) >= 0) && bht) ||
          npc_pred_f !== exp_npc) begin
        bad++; $display("FAIL rand_lookup pcf=%h hit=%b pt=%b npc=%h want npc=%h", pcf,
                        btb_hit_f, pred_taken_f, npc_pred_f, exp_npc);
      end
      total++;
      if (mispredict_e !== model_mis() ||
          (mispredict_e === 1'b1 && redirect_pc_e !== model_redirect())) begin
        bad++; $display("FAIL rand_resolve pce=%h mis=%b redir=%h want %b %h", pce,
                        mispredict_e, redirect_pc_e, model_mis(), model_redirect());
      end
      tick();
      total++;
      if (hit_count !== CNT_W'(m_hits) || mispredict_count !== CNT_W'(m_mis)) begin
        bad++; $display("FAIL rand_counters hits=%0d mis=%0d want %0d %0d", hit_count,
                        mispredict_count, m_hits, m_mis);
      end
    end
  endtask

  task automatic test_async_reset();
    set_in(32'h40, 1'b1, 32'h40, BR_BEQ, 1'b1, 32'h200, 1'b0, 32'h44);
    tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (btb_hit_f !== 1'b0 || pred_taken_f !== 1'b0 || npc_pred_f !== 32'h44 ||
        hit_count !== '0 || mispredict_count !== '0) begin
      bad++; $display("FAIL async_reset hit=%b pt=%b npc=%h hits=%0d mis=%0d want 0 0 00000044 0 0",
                      btb_hit_f, pred_taken_f, npc_pred_f, hit_count, mispredict_count);
    end
    total++;
    if (mispredict_e !== 1'b1) begin
      bad++; $display("FAIL reset_resolve mis=%b want 1", mispredict_e);
    end
    tick();
    rst = 1'b0;
    tick();
    set_in(32'h40, 1'b1, 32'h0, NOBRANCH, 1'b0, 32'h0, 1'b0, 32'h0);
    total++;
    if (npc_pred_f !== 32'h200 || mispredict_count !== 4'd1) begin
      bad++; $display("FAIL post_reset_train npc=%h mis=%0d want 00000200 1", npc_pred_f, mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_mispredict();
    test_eviction();
    test_target_mismatch();
    test_not_taken();
    test_wrap();
    test_saturation();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Fetch-stage next-PC predictor that pairs a 2-way set-associative branch target buffer with the direction bit from the branch history table. In IF it produces the predicted next PC from the current PC. In EX it compares the resolved branch against the carried prediction, raises mispredict/redirect, and trains the BTB. It feeds the PC register mux and the IF/ID prediction pipeline fields, and keeps its own accuracy counters.

## Interface
- SETS, 32: BTB sets, power of two; INDEX_W = log2(SETS).
- CNT_W, 16: statistics counter width.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high. Clock is clk.
- PCF  in  32  fetch PC.
- bht_taken_f  in  1  BHT direction prediction for PCF.
- npc_pred_f  out  32  predicted next fetch PC.
- pred_taken_f  out  1  prediction taken; carried down the pipe to EX.
- btb_hit_f  out  1  PCF tag match in a valid way.
- PCE  in  32  EX-stage branch PC.
- branch_type_e  in  3  branch type; NOBRANCH means no branch in EX.
- real_taken_e  in  1  resolved direction.
- real_target_e  in  32  resolved target.
- pred_taken_e  in  1  pred_taken_f carried to EX.
- pred_target_e  in  32  npc_pred_f carried to EX.
- mispredict_e  out  1  flush IF/ID and ID/EX, load redirect_pc_e.
- redirect_pc_e  out  32  correct next PC.
- hit_count, mispredict_count  out  CNT_W each  statistics.

## Operation
- Index = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2]. Each way entry = {valid, tag, target[31:0]}. Each set has one LRU bit, naming the way to evict next.
- Lookup (combinational):
  - btb_hit_f = match in way0 or way1.
  - pred_taken_f = btb_hit_f & bht_taken_f.
  - npc_pred_f = pred_taken_f ? hit target : PCF+4.
  - If both ways match, way0 wins (only reachable by corruption; not legal after reset).
- Resolve (combinational, only when branch_type_e != NOBRANCH; otherwise mispredict_e=0):
  - mispredict_e = (pred_taken_e != real_taken_e) | (pred_taken_e & real_taken_e & pred_target_e != real_target_e).
  - redirect_pc_e = real_taken_e ? real_target_e : PCE+4. It is always driven, and is only meaningful when mispredict_e=1.
- Train (posedge clk, branch in EX):
  - Taken and hit in PCE set: overwrite that way's target; LRU := other way.
  - Taken and miss: allocate into the first invalid way (way0 before way1), else the LRU way. Write valid=1, tag, and target; LRU := other way.
  - Not taken: entries unchanged. A hit still sets LRU := other way. Direction belongs to the BHT.
- Counters, on a branch in EX:
  - hit_count increments when pred_taken_e=1 and mispredict_e=0.
  - mispredict_count increments when mispredict_e=1.
  - Both saturate at all-ones; no wrap.
- PC adders are 32-bit modulo (0xFFFF_FFFC+4 = 0).

## Timing
- Lookup and resolve: zero-cycle, asynchronous array read.
- Update: visible to lookups from the cycle after the clock edge.
- Same-cycle lookup and update to the same set: the lookup sees pre-update contents (read-before-write).
- Reset:
  - All valid bits, LRU bits, and counters go to 0 immediately, without waiting for clk.
  - Targets and tags are don't-care.
  - During and after reset, btb_hit_f=0, pred_taken_f=0, and npc_pred_f=PCF+4.
  - mispredict_e follows its inputs combinationally.
- rst deasserting mid-stream: the first edge after deassert may train normally.

## Structure
- Shared package bp_pkg holds:
  - the branch-type encoding, including NOBRANCH, shared with the BHT and decoder;
  - btb_entry_t {valid, tag, target};
  - default SETS/CNT_W constants.
- Sub-module btb_way: one way's valid/tag/target arrays, with async read, sync write, and async valid clear. Instantiated twice.
- The top level holds LRU bits, hit/replace logic, resolve logic, and counters.

## Test plan
- Reset, then PCF=0x0000_0040 with bht_taken_f=1 -> btb_hit_f=0, npc_pred_f=0x0000_0044. Both counters 0.
- Branch at PCE=0x40, taken, target 0x100, pred_taken_e=0, pred_target_e=0x44 -> mispredict_e=1, redirect_pc_e=0x100, mispredict_count=1. Next cycle PCF=0x40 with bht_taken_f=1 -> npc_pred_f=0x100.
- Three taken branches to set 0 (PCs 0x000, 0x080, 0x100; SETS=32) -> third evicts 0x000 (LRU). Lookup 0x000 misses; 0x080 and 0x100 hit.
- Correct taken prediction with target mismatch (pred_target_e=0x100, real_target_e=0x200) -> mispredict_e=1, redirect 0x200. Entry retrained to 0x200.
- Not-taken branch at 0x40 predicted not-taken -> mispredict_e=0, no counter change. Then predicted taken but resolved not-taken -> redirect_pc_e=0x44.
- Force mispredict_count to all-ones, then another mispredict -> count stays at all-ones. Assert rst mid-cycle -> hit outputs and counters clear without a clock edge.
